ball_vector: RTL and testbench

Ball-motion stage downstream of `cordic`. On a launch request it drives `cordic` with the launch angle, waits the fixed CORDIC latency, and scales the returned cosine/sine into a signed sub-pixel velocity. It then advances the ball position once per frame tick, reflecting off the top and bottom walls and reporting left/right exits to the score logic. Its outputs feed the renderer and the paddle-collision logic, which issues new launches.

---
 rtl/ball_vector.sv | 172 +++++++++++++++++
 tb/tb_ball_vector.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_vector.sv
// Ball-motion stage: launches a CORDIC lookup, scales cos/sin into a Q10.8 velocity,
// then steps the ball once per frame with top/bottom reflection and left/right exit.
module ball_vector #(
    parameter int unsigned CORDIC_LAT = 34,
    parameter int unsigned X_MAX      = 639,
    parameter int unsigned Y_MAX      = 479
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        launch,
    input  logic [31:0] launch_angle,
    input  logic [9:0]  launch_x,
    input  logic [9:0]  launch_y,
    input  logic [7:0]  speed,
    input  logic        frame_tick,
    output logic        cordic_start,
    output logic [31:0] cordic_angle,
    input  logic [31:0] cos_in,
    input  logic [31:0] sin_in,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [17:0] vel_x,
    output logic [17:0] vel_y,
    output logic        busy,
    output logic        moving,
    output logic        wall_bounce,
    output logic        out_left,
    output logic        out_right
);

    localparam int unsigned     CNT_W = $clog2(CORDIC_LAT + 1);
    localparam logic signed [19:0] X_LIM = 20'(X_MAX << 8);
    localparam logic signed [19:0] Y_LIM = 20'(Y_MAX << 8);
    localparam logic signed [19:0] X_CTR = 20'((X_MAX >> 1) << 8);
    localparam logic signed [19:0] Y_CTR = 20'((Y_MAX >> 1) << 8);

    typedef enum logic [2:0] {IDLE, START, WAIT, SCALE, RUN} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        angle_q;
    logic [7:0]         speed_q;
    logic signed [31:0] cos_q;
    logic signed [31:0] sin_q;
    logic signed [19:0] x_q;
    logic signed [19:0] y_q;
    logic signed [17:0] vel_x_q;
    logic signed [17:0] vel_y_q;
    logic               cordic_start_q;
    logic               busy_q;
    logic               moving_q;
    logic               wall_bounce_q;
    logic               out_left_q;
    logic               out_right_q;

    logic signed [40:0] prod_x;
    logic signed [40:0] prod_y;
    logic signed [19:0] nx;
    logic signed [19:0] ny;
    logic               unused_prod;

    // Unit-vector Q2.30 times unsigned speed; bits [39:22] are the Q10.8 velocity.
    assign prod_x      = 41'(cos_q) * 41'($signed({1'b0, speed_q}));
    assign prod_y      = 41'(sin_q) * 41'($signed({1'b0, speed_q}));
    assign unused_prod = ^{prod_x[40], prod_x[21:0], prod_y[40], prod_y[21:0]};

    assign nx = x_q + 20'(vel_x_q);
    assign ny = y_q + 20'(vel_y_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            angle_q        <= '0;
            speed_q        <= '0;
            cos_q          <= '0;
            sin_q          <= '0;
            x_q            <= X_CTR;
            y_q            <= Y_CTR;
            vel_x_q        <= '0;
            vel_y_q        <= '0;
            cordic_start_q <= 1'b0;
            busy_q         <= 1'b0;
            moving_q       <= 1'b0;
            wall_bounce_q  <= 1'b0;
            out_left_q     <= 1'b0;
            out_right_q    <= 1'b0;
        end else begin
            cordic_start_q <= 1'b0;
            wall_bounce_q  <= 1'b0;
            out_left_q     <= 1'b0;
            out_right_q    <= 1'b0;
            if (launch) begin
                // A new launch supersedes whatever is in flight, including a pending move.
                angle_q        <= launch_angle;
                speed_q        <= speed;
                x_q            <= {2'b00, launch_x, 8'h00};
                y_q            <= {2'b00, launch_y, 8'h00};
                cnt_q          <= '0;
                state_q        <= START;
                cordic_start_q <= 1'b1;
                busy_q         <= 1'b1;
                moving_q       <= 1'b0;
            end else begin
                case (state_q)
                    START: begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_W'(1);
                    end
                    WAIT: begin
                        if (cnt_q == CNT_W'(CORDIC_LAT)) begin
                            cos_q   <= cos_in;
                            sin_q   <= sin_in;
                            state_q <= SCALE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    SCALE: begin
                        vel_x_q  <= prod_x[39:22];
                        vel_y_q  <= prod_y[39:22];
                        state_q  <= RUN;
                        busy_q   <= 1'b0;
                        moving_q <= 1'b1;
                    end
                    RUN: begin
                        if (frame_tick) begin
                            if (ny < 0) begin
                                y_q           <= '0;
                                vel_y_q       <= -vel_y_q;
                                wall_bounce_q <= 1'b1;
                            end else if (ny > Y_LIM) begin
                                y_q           <= Y_LIM;
                                vel_y_q       <= -vel_y_q;
                                wall_bounce_q <= 1'b1;
                            end else begin
                                y_q <= ny;
                            end
                            if (nx < 0) begin
                                x_q        <= '0;
                                out_left_q <= 1'b1;
                                state_q    <= IDLE;
                                moving_q   <= 1'b0;
                            end else if (nx > X_LIM) begin
                                x_q         <= X_LIM;
                                out_right_q <= 1'b1;
                                state_q     <= IDLE;
                                moving_q    <= 1'b0;
                            end else begin
                                x_q <= nx;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cordic_start = cordic_start_q;
    assign cordic_angle = angle_q;
    assign ball_x       = x_q[17:8];
    assign ball_y       = y_q[17:8];
    assign vel_x        = vel_x_q;
    assign vel_y        = vel_y_q;
    assign busy         = busy_q;
    assign moving       = moving_q;
    assign wall_bounce  = wall_bounce_q;
    assign out_left     = out_left_q;
    assign out_right    = out_right_q;

endmodule

// File: tb/tb_ball_vector.sv
// Self-checking bench for ball_vector: behavioural CORDIC, vector table, velocity scoreboard.
module tb_ball_vector;

    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        launch = 1'b0;
    logic [31:0] launch_angle = '0;
    logic [9:0]  launch_x = '0;
    logic [9:0]  launch_y = '0;
    logic [7:0]  speed = '0;
    logic        frame_tick = 1'b0;
    logic        cordic_start;
    logic [31:0] cordic_angle;
    logic [31:0] cos_in = '0;
    logic [31:0] sin_in = '0;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic [17:0] vel_x;
    logic [17:0] vel_y;
    logic        busy;
    logic        moving;
    logic        wall_bounce;
    logic        out_left;
    logic        out_right;

    int checks = 0;
    int failures = 0;
    int starts = 0;

    typedef struct {
        int vx;
        int vy;
    } vel_t;
    vel_t exp_q[$];

    always #5 clk = ~clk;

    ball_vector #(.CORDIC_LAT(LAT), .X_MAX(639), .Y_MAX(479)) dut (
        .clk(clk), .reset(reset), .launch(launch), .launch_angle(launch_angle),
        .launch_x(launch_x), .launch_y(launch_y), .speed(speed), .frame_tick(frame_tick),
        .cordic_start(cordic_start), .cordic_angle(cordic_angle),
        .cos_in(cos_in), .sin_in(sin_in), .ball_x(ball_x), .ball_y(ball_y),
        .vel_x(vel_x), .vel_y(vel_y), .busy(busy), .moving(moving),
        .wall_bounce(wall_bounce), .out_left(out_left), .out_right(out_right)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, expv, $time);
        end
    endtask

    // Behavioural CORDIC: answers only in the cycle LAT after the start pulse, junk otherwise.
    int          c_cnt = 0;
    logic [31:0] c_ang = '0;
    always @(negedge clk) begin
        if (reset) c_cnt = 0;
        else if (cordic_start) begin
            c_cnt = 1;
            c_ang = cordic_angle;
        end else if (c_cnt != 0 && c_cnt < 1000) c_cnt++;
        if (c_cnt == LAT + 1) begin
            case (c_ang)
                32'h0000_0000: begin cos_in = 32'h4000_0000; sin_in = 32'h0000_0000; end
                32'h4000_0000: begin cos_in = 32'h0000_0000; sin_in = 32'h4000_0000; end
                32'h8000_0000: begin cos_in = 32'hC000_0000; sin_in = 32'h0000_0000; end
                32'hE000_0000: begin cos_in = 32'h2D41_3CCD; sin_in = 32'hD2BE_C333; end
                default:       begin cos_in = 32'h1234_5678; sin_in = 32'h8765_4321; end
            endcase
        end else begin
            cos_in = 32'h1234_5678;
            sin_in = 32'h8765_4321;
        end
    end

    // Monitor: start-pulse count, state exclusivity, and scoreboard pop on entry to RUN.
    logic mov_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (cordic_start) starts++;
            chk("busy_moving_excl", 32'(busy & moving), 32'd0);
            if (moving && !mov_prev) begin
                if (exp_q.size() == 0) chk("unexpected_run", 32'd1, 32'd0);
                else begin
                    vel_t e;
                    e = exp_q.pop_front();
                    chk("sb_vel_x", 32'($signed(vel_x)), 32'(e.vx));
                    chk("sb_vel_y", 32'($signed(vel_y)), 32'(e.vy));
                end
            end
        end
        mov_prev = moving;
    end

    task automatic do_launch(input logic [31:0] ang, input logic [7:0] spd, input logic [9:0] lx,
                             input logic [9:0] ly, input int evx, input int evy, input bit tk);
        vel_t e;
        launch_angle = ang; speed = spd; launch_x = lx; launch_y = ly;
        launch = 1'b1; frame_tick = tk;
        e.vx = evx; e.vy = evy;
        exp_q.delete();
        exp_q.push_back(e);
        @(posedge clk); #1;
        launch = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic wait_moving(output int nb);
        bit done;
        nb = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (moving) done = 1;
            else if (busy) nb++;
        end
        if (!done) chk("run_timeout", 32'd0, 32'd1);
    endtask

    task automatic tick(output bit wb, output bit ol, output bit orr);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(negedge clk);
        wb = wall_bounce; ol = out_left; orr = out_right;
    endtask

    typedef struct {
        logic [31:0] ang;
        logic [7:0]  spd;
        logic [9:0]  lx;
        logic [9:0]  ly;
        int          nt;
        int          vx, vy, bx, by, vyf;
        bit          wb, ol, orr, mv;
    } vec_t;
    vec_t tv[7];

    initial begin : main
        int nb, s0;
        bit wb, ol, orr, awb, aol, aor;
        tv[0] = '{32'h0000_0000, 8'd4, 10'd320, 10'd240, 3, 1024, 0, 332, 240, 0, 0, 0, 0, 1};
        tv[1] = '{32'hE000_0000, 8'd8, 10'd100, 10'd2,   1, 1448, -1449, 105, 0, 1449, 1, 0, 0, 1};
        tv[2] = '{32'h4000_0000, 8'd2, 10'd10,  10'd477, 1, 0, 512, 10, 479, 512, 0, 0, 0, 1};
        tv[3] = '{32'h4000_0000, 8'd2, 10'd10,  10'd478, 1, 0, 512, 10, 479, -512, 1, 0, 0, 1};
        tv[4] = '{32'h8000_0000, 8'd5, 10'd3,   10'd100, 3, -1280, 0, 0, 100, 0, 0, 1, 0, 0};
        tv[5] = '{32'h0000_0000, 8'd4, 10'd636, 10'd50,  1, 1024, 0, 639, 50, 0, 0, 0, 1, 0};
        tv[6] = '{32'hE000_0000, 8'd8, 10'd639, 10'd1,   1, 1448, -1449, 639, 0, 1449, 1, 0, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ball_x", 32'(ball_x), 32'd319);
        chk("rst_ball_y", 32'(ball_y), 32'd239);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_moving", 32'(moving), 32'd0);
        chk("rst_vel", {14'd0, vel_x} | {14'd0, vel_y}, 32'd0);
        chk("rst_cstart", 32'(cordic_start), 32'd0);
        chk("rst_angle", cordic_angle, 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            @(posedge clk); #1;
            s0 = starts;
            do_launch(tv[v].ang, tv[v].spd, tv[v].lx, tv[v].ly, tv[v].vx, tv[v].vy, 1'b0);
            wait_moving(nb);
            chk("busy_cycles", 32'(nb), 32'd36);
            chk("start_pulses", 32'(starts - s0), 32'd1);
            awb = 0; aol = 0; aor = 0;
            for (int t = 0; t < tv[v].nt; t++) begin
                tick(wb, ol, orr);
                awb |= wb; aol |= ol; aor |= orr;
            end
            chk("ball_x", 32'(ball_x), 32'(tv[v].bx));
            chk("ball_y", 32'(ball_y), 32'(tv[v].by));
            chk("vel_y_final", 32'($signed(vel_y)), 32'(tv[v].vyf));
            chk("wall_bounce", 32'(awb), 32'(tv[v].wb));
            chk("out_left", 32'(aol), 32'(tv[v].ol));
            chk("out_right", 32'(aor), 32'(tv[v].orr));
            chk("moving_final", 32'(moving), 32'(tv[v].mv));
            @(negedge clk);
            chk("pulses_one_cycle", 32'({wall_bounce, out_left, out_right}), 32'd0);
        end

        // Relaunch at WAIT counter 10: second angle's values, one extra start pulse.
        @(posedge clk); #1;
        s0 = starts;
        do_launch(32'h8000_0000, 8'd5, 10'd300, 10'd300, -1280, 0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        do_launch(32'h0000_0000, 8'd4, 10'd300, 10'd300, 1024, 0, 1'b0);
        wait_moving(nb);
        chk("relaunch_busy", 32'(nb), 32'd36);
        chk("relaunch_starts", 32'(starts - s0), 32'd2);
        chk("relaunch_angle", cordic_angle, 32'h0000_0000);

        // Launch and frame_tick together during RUN: load wins, no move.
        @(posedge clk); #1;
        do_launch(32'h0000_0000, 8'd4, 10'd200, 10'd150, 1024, 0, 1'b1);
        @(negedge clk);
        chk("lt_ball_x", 32'(ball_x), 32'd200);
        chk("lt_ball_y", 32'(ball_y), 32'd150);
        chk("lt_busy", 32'(busy), 32'd1);
        wait_moving(nb);
        chk("lt_ball_x_run", 32'(ball_x), 32'd200);

        // Reset mid-RUN: immediate reset values, ticks ignored afterwards.
        #1 reset = 1'b1;
        #1;
        exp_q.delete();
        chk("rr_ball_x", 32'(ball_x), 32'd319);
        chk("rr_ball_y", 32'(ball_y), 32'd239);
        chk("rr_moving", 32'(moving), 32'd0);
        chk("rr_vel_x", 32'(vel_x), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        tick(wb, ol, orr);
        chk("rr_tick_ball_x", 32'(ball_x), 32'd319);
        chk("rr_tick_pulses", 32'({wb, ol, orr}), 32'd0);

        // Reset during START: start pulse drops at once and the request is abandoned.
        @(posedge clk); #1;
        do_launch(32'h4000_0000, 8'd2, 10'd10, 10'd10, 0, 512, 1'b0);
        chk("rw_cstart_before", 32'(cordic_start), 32'd1);
        #1 reset = 1'b1;
        #1;
        exp_q.delete();
        chk("rw_cstart", 32'(cordic_start), 32'd0);
        chk("rw_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("rw_no_resume_busy", 32'(busy), 32'd0);
        chk("rw_no_resume_moving", 32'(moving), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
